// File: rtl/btn_debounce.sv
// Push-button bank conditioner: per-channel 2-flop synchroniser, stability counter,
// debounced level and registered press/release strobes plus a lagging "any press" strobe.
module btn_debounce #(
    parameter int WIDTH         = 7,
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic             btn_any
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic             any_q, any_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        any_d     = |press_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Any sample matching the accepted level restarts the count.
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_any     = any_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: a STABLE_CYCLES=4 instance for the main scenarios
// and a STABLE_CYCLES=1 instance for the minimum-latency build.
module tb_btn_debounce;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic [6:0] raw_a   = '0;
    logic [6:0] raw_b   = '0;
    logic [6:0] level_a, press_a, release_a;
    logic [6:0] level_b, press_b, release_b;
    logic       any_a, any_b;

    int vectors    = 0;
    int miscompares = 0;

    always #20 clk_sys = ~clk_sys;

    btn_debounce #(.WIDTH(7), .STABLE_CYCLES(4)) u_dut_a (
        .clk(clk_sys), .rst_n(rst_n), .btn_raw(raw_a),
        .btn_level(level_a), .btn_press(press_a), .btn_release(release_a), .btn_any(any_a)
    );

    btn_debounce #(.WIDTH(7), .STABLE_CYCLES(1)) u_dut_b (
        .clk(clk_sys), .rst_n(rst_n), .btn_raw(raw_b),
        .btn_level(level_b), .btn_press(press_b), .btn_release(release_b), .btn_any(any_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    logic [7:0] bpat;
    int         n_press;
    int         n_any;

    initial begin
        // Reset with every button held
        raw_a = 7'h7F;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("rst_outs_a", {level_a, press_a, release_a, any_a}, 0);
            check_val("rst_outs_b", {level_b, press_b, release_b, any_b}, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rst_rel_wait", {level_a, press_a, any_a}, 0);
        end
        step();
        check_val("rst_rel_level", level_a, 7'h7F);
        check_val("rst_rel_press", press_a, 7'h7F);
        check_val("rst_rel_any_lag", any_a, 0);
        step();
        check_val("rst_rel_press_off", press_a, 0);
        check_val("rst_rel_any", any_a, 1);
        step();
        check_val("rst_rel_any_off", any_a, 0);
        check_val("rst_rel_level_hold", level_a, 7'h7F);
        raw_a = 7'h00;
        idle(5);
        check_val("all_release_wait", release_a, 0);
        step();
        check_val("all_release", release_a, 7'h7F);
        check_val("all_release_lvl", level_a, 0);
        check_val("all_release_any", any_a, 0);
        step();
        check_val("all_release_off", release_a, 0);
        idle(3);

        // Clean press and release on bit 2
        raw_a = 7'h04;
        idle(5);
        check_val("b2_press_early", {level_a, press_a}, 0);
        step();
        check_val("b2_level", level_a, 7'h04);
        check_val("b2_press", press_a, 7'h04);
        step();
        check_val("b2_press_off", press_a, 0);
        check_val("b2_any", any_a, 1);
        idle(3);
        raw_a = 7'h00;
        idle(5);
        check_val("b2_release_early", {level_a, release_a}, {7'h04, 7'h00});
        step();
        check_val("b2_release_lvl", level_a, 0);
        check_val("b2_release", release_a, 7'h04);
        check_val("b2_release_press", press_a, 0);
        step();
        check_val("b2_release_off", release_a, 0);
        check_val("b2_release_any", any_a, 0);
        idle(3);

        // Bounce on bit 1: never four consecutive highs
        bpat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            raw_a = {5'b0, bpat[k], 1'b0};
            step();
            check_val("bounce_quiet", {level_a, press_a, release_a}, 0);
        end
        raw_a   = 7'h02;
        n_press = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (press_a[1]) n_press++;
        end
        check_val("bounce_press_cnt", n_press, 1);
        check_val("bounce_level", level_a, 7'h02);
        raw_a = 7'h00;
        idle(8);
        check_val("bounce_cleared", level_a, 0);

        // Simultaneous press on bits 0 and 6
        raw_a = 7'h41;
        idle(5);
        check_val("simul_early", press_a, 0);
        step();
        check_val("simul_press", press_a, 7'h41);
        check_val("simul_level", level_a, 7'h41);
        n_any = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (any_a) n_any++;
            if (k == 0) check_val("simul_any_first", any_a, 1);
        end
        check_val("simul_any_cnt", n_any, 1);
        raw_a = 7'h00;
        idle(8);

        // Reset mid-count on bit 3
        raw_a = 7'h08;
        idle(2);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("midrst_quiet", {level_a, press_a, release_a, any_a}, 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("midrst_wait", {level_a, press_a}, 0);
        end
        step();
        check_val("midrst_press", press_a, 7'h08);
        step();
        check_val("midrst_press_off", press_a, 0);
        raw_a = 7'h00;
        idle(8);

        // STABLE_CYCLES=1: single-cycle raw pulse on bit 4
        raw_b = 7'h10;
        step();
        raw_b = 7'h00;
        step();
        check_val("s1_early", {level_b, press_b}, 0);
        step();
        check_val("s1_press", press_b, 7'h10);
        check_val("s1_level", level_b, 7'h10);
        step();
        check_val("s1_release", release_b, 7'h10);
        check_val("s1_press_off", press_b, 0);
        check_val("s1_level_off", level_b, 0);
        check_val("s1_any", any_b, 1);
        step();
        check_val("s1_release_off", release_b, 0);
        check_val("s1_any_off", any_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Synchronises and debounces the board push-button bank (`btn[6:0]`) on the 25 MHz system clock. For each button it provides a clean level and single-cycle press/release strobes. It sits directly between the raw `btn` pads and the application logic in `top` (counters, LED logic, and later CPU GPIO). Downstream logic must never sample raw pad inputs.

## Interface

Parameters:
- `WIDTH`, 7, number of buttons handled; one independent channel per bit.
- `STABLE_CYCLES`, 250000, consecutive synchronised cycles a new value must hold before it is accepted (10 ms at 25 MHz). Legal range is 1 to 2^24.
- `CNT_W`, `$clog2(STABLE_CYCLES+1)`, width of the per-channel stability counter. Derived; not overridden by users.

Ports:
- `clk`  input  1  system clock, 25 MHz; all logic on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `btn_raw`  input  WIDTH  asynchronous pad inputs, 1 = pressed.
- `btn_level`  output  WIDTH  debounced level per button, registered.
- `btn_press`  output  WIDTH  one-cycle strobe when `btn_level` bit rises 0→1.
- `btn_release`  output  WIDTH  one-cycle strobe when `btn_level` bit falls 1→0.
- `btn_any`  output  1  registered OR of `btn_press`; one-cycle strobe for "some button pressed".

## Operation

- Each channel has its own 2-flop synchroniser: `sync1 <= btn_raw[i]` and `sync2 <= sync1`. `btn_raw` feeds only `sync1`; no other logic reads it.
- Each channel has a stability counter `cnt` (CNT_W bits) and an accepted state, `btn_level[i]`.
- Per clock edge, per channel, with `rst_n` high:
  - `sync2 == btn_level`: `cnt <= 0`. Any bounce back to the accepted value restarts the count.
  - `sync2 != btn_level` and `cnt != STABLE_CYCLES-1`: `cnt <= cnt + 1`.
  - `sync2 != btn_level` and `cnt == STABLE_CYCLES-1`: `btn_level <= sync2`, `cnt <= 0`. Assert `btn_press` if `sync2` is 1, or `btn_release` if `sync2` is 0, for this one cycle.
- Strobes are registered and high for exactly one cycle per accepted transition. A channel can never assert `btn_press` and `btn_release` together.
- `cnt` never exceeds STABLE_CYCLES-1 and never wraps. Saturation is implicit in the accept rule.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous strobes on those bits.
- `btn_any` is registered, so it lags `btn_press` by one cycle. It is high for exactly one cycle per edge on which any `btn_press` bit was high.
- Reset (`rst_n` low at a rising edge) sets the following to 0: `sync1`, `sync2`, `cnt`, `btn_level`, `btn_press`, `btn_release`, `btn_any`. Reset is honoured mid-count and mid-strobe.
  - After reset is released, a button held throughout reset is accepted as a fresh press after the normal latency. It produces one `btn_press`.

## Timing

- Reset values: all outputs are 0.
- Latency: let `btn_raw[i]` take a new value before rising edge E0 and hold it. `sync2` shows the value after edge E0+1, and `btn_level[i]` plus the matching strobe update at edge E0+STABLE_CYCLES+1.
  - With STABLE_CYCLES=4, the update lands at E0+5.
- `btn_any` follows at edge E0+STABLE_CYCLES+2.
- A glitch shorter than STABLE_CYCLES synchronised cycles produces no output change and no strobe.
- Minimum spacing between two accepted transitions on one channel is STABLE_CYCLES cycles.
- No combinational path from any input to any output.

## Test plan

All scenarios use STABLE_CYCLES=4 and WIDTH=7.
- Reset: hold `rst_n`=0 for 3 cycles with `btn_raw`=7'h7F. All outputs stay 0 throughout. After release, `btn_level` becomes 7'h7F at the 6th edge, with `btn_press`=7'h7F for one cycle, then `btn_any`=1 for one cycle.
- Clean press/release on bit 2: set `btn_raw`=7'h04 before E0. Then `btn_level[2]`=1 and `btn_press[2]`=1 at E0+5, only for that cycle. Clear to 0 at E10. Then `btn_level[2]`=0 and `btn_release[2]`=1 at E15.
- Bounce: toggle bit 1 as 1,1,1,0,1,1,1,0 (3 cycles high, 1 low, repeated). No strobe and `btn_level[1]` stays 0. Then hold 1 for 4+ cycles: exactly one `btn_press[1]`.
- Simultaneous: drive bits 0 and 6 from 0 to 1 on the same edge. Both `btn_press` bits assert on the same cycle, and `btn_any` is a single one-cycle pulse.
- Reset mid-count: raise bit 3 and assert `rst_n`=0 after 2 cycles. `cnt` and outputs clear, and no strobe appears during reset. After release with bit 3 still high, `btn_press[3]` fires 5 edges later.
- STABLE_CYCLES=1 build: a single-cycle raw pulse is accepted at E0+2, and a 1-cycle release strobe follows the next change.
